// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: ALUCtl codes, FSM encoding, shift width.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned SHAMT_W      = $clog2(XLEN_DEFAULT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: loads an operand and count, then shifts one bit per step until the count
// is exhausted. o_next is the value the current step produces.
module alu_shift_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_right,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_data,
  input  logic [SHW-1:0]  i_shamt,
  output logic            o_done,
  output logic [XLEN-1:0] o_next
);

  logic [XLEN-1:0] r_data;
  logic [SHW-1:0]  r_cnt;
  logic            r_right;
  logic            r_arith;
  logic [XLEN-1:0] w_step;

  always_comb begin
    w_step = {r_data[XLEN-2:0], 1'b0};
    if (r_right) begin
      w_step = {r_arith & r_data[XLEN-1], r_data[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_right <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_cnt   <= i_shamt;
      r_right <= i_right;
      r_arith <= i_arith;
    end else if (i_step && (r_cnt != '0)) begin
      r_data <= w_step;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  // The step taken while the count is 1 is the final one.
  assign o_done = (r_cnt[SHW-1:1] == '0);
  assign o_next = w_step;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides, registered result/zero/illegal and an
// iterative (or optional single-cycle) shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FAST_SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;

  logic            w_accept;
  logic            w_is_shift;
  logic            w_iter;
  logic            w_sh_done;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_calc;
  logic [XLEN-1:0] w_sh_next;
  logic            w_illegal;

  assign w_shamt    = op_b[SHW-1:0];
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = alu_ctl inside {ALU_SLL, ALU_SRL, ALU_SRA};
  assign w_iter     = (FAST_SHIFT == 0) && w_is_shift && (w_shamt != '0);

  // Without FAST_SHIFT the single-cycle path only ever sees shamt==0, so it is a pass-through.
  always_comb begin
    w_calc    = '0;
    w_illegal = 1'b0;
    case (alu_ctl)
      ALU_AND:  w_calc = op_a & op_b;
      ALU_OR:   w_calc = op_a | op_b;
      ALU_ADD:  w_calc = op_a + op_b;
      ALU_XOR:  w_calc = op_a ^ op_b;
      ALU_SUB:  w_calc = op_a - op_b;
      ALU_SLL:  w_calc = (FAST_SHIFT != 0) ? (op_a << w_shamt) : op_a;
      ALU_SRL:  w_calc = (FAST_SHIFT != 0) ? (op_a >> w_shamt) : op_a;
      ALU_SRA:  w_calc = (FAST_SHIFT != 0) ? $unsigned($signed(op_a) >>> w_shamt) : op_a;
      ALU_SLT:  w_calc = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: w_calc = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:  w_illegal = 1'b1;
    endcase
  end

  if (FAST_SHIFT == 0) begin : g_iter_shift
    alu_shift_iter #(
      .XLEN (XLEN),
      .SHW  (SHW)
    ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept && w_iter),
      .i_step  (r_state == S_SHIFT),
      .i_right (alu_ctl != ALU_SLL),
      .i_arith (alu_ctl == ALU_SRA),
      .i_data  (op_a),
      .i_shamt (w_shamt),
      .o_done  (w_sh_done),
      .o_next  (w_sh_next)
    );
  end else begin : g_no_iter_shift
    assign w_sh_done = 1'b1;
    assign w_sh_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_iter ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (w_sh_done) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept)       w_state_next = w_iter ? S_SHIFT : S_DONE;
        else if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_iter) begin
      r_result  <= w_calc;
      r_zero    <= (w_calc == '0);
      r_illegal <= w_illegal;
    end else if ((r_state == S_SHIFT) && w_sh_done) begin
      r_result  <= w_sh_next;
      r_zero    <= (w_sh_next == '0);
      r_illegal <= 1'b0;
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (XLEN=32, iterative shifter): directed vector table, hand-written
// handshake/backpressure/reset sequences and random ops against a behavioural model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(
    .XLEN       (32),
    .FAST_SHIFT (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: {illegal, result} from the operation definitions.
  function automatic logic [32:0] model(input logic [3:0] ctl, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = b % 32;
    case (ctl)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a ^ b;
      4'd4: r = a << s;
      4'd5: r = a >> s;
      4'd6: r = a - b;
      4'd7: r = $unsigned($signed(a) >>> s);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r};
  endfunction

  function automatic int model_lat(input logic [3:0] ctl, input logic [31:0] b);
    if ((ctl == 4'd4 || ctl == 4'd5 || ctl == 4'd7) && (b % 32) != 0) return int'(b % 32) + 1;
    return 1;
  endfunction

  // One complete op with out_ready=1; inputs are scrambled right after the accept edge.
  task automatic run_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic ill,
                        output int lat, output int busy);
    int n;
    in_valid = 1'b1;
    alu_ctl  = ctl;
    op_a     = a;
    op_b     = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctl  = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    lat  = 0;
    busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready && !out_valid) busy++;
    end while (!out_valid && lat < 100);
    res = result;
    z   = zero;
    ill = illegal;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[14];
  logic [31:0] g_res;
  logic        g_z;
  logic        g_ill;
  int          g_lat;
  int          g_busy;
  logic [32:0] m;
  logic        seen;

  initial begin
    vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1};
    vecs[1]  = '{4'b0110, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b0, 1};
    vecs[2]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
    vecs[3]  = '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[4]  = '{4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5};
    vecs[5]  = '{4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};
    vecs[6]  = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1};
    vecs[7]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1};
    vecs[8]  = '{4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1};
    vecs[9]  = '{4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1};
    vecs[10] = '{4'b0101, 32'h8000_0000, 32'hFFFF_FF01, 32'h4000_0000, 1'b0, 2};
    vecs[11] = '{4'b0100, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[12] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[13] = '{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_ctl   = 4'd0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", 32'(zero), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, g_res, g_z, g_ill, g_lat, g_busy);
      chk($sformatf("vec%0d result", i), g_res, vecs[i].res);
      chk($sformatf("vec%0d zero", i), 32'(g_z), 32'(vecs[i].res == 32'd0));
      chk($sformatf("vec%0d illegal", i), 32'(g_ill), 32'(vecs[i].ill));
      chk($sformatf("vec%0d latency", i), 32'(g_lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d busy", i), 32'(g_busy), 32'(vecs[i].lat - 1));
    end

    // Back-to-back SUB, SLT, SLTU on three consecutive accept edges.
    @(negedge clk);
    in_valid = 1'b1; alu_ctl = 4'b0110; op_a = 32'h1234; op_b = 32'h1234;
    chk("b2b accept0 in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    alu_ctl = 4'b1000; op_a = 32'hFFFF_FFFF; op_b = 32'h1;
    @(negedge clk);
    chk("b2b sub valid", 32'(out_valid), 32'd1);
    chk("b2b sub result", result, 32'd0);
    chk("b2b sub zero", 32'(zero), 32'd1);
    chk("b2b accept1 in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    alu_ctl = 4'b1001;
    @(negedge clk);
    chk("b2b slt valid", 32'(out_valid), 32'd1);
    chk("b2b slt result", result, 32'd1);
    chk("b2b slt zero", 32'(zero), 32'd0);
    chk("b2b accept2 in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b sltu valid", 32'(out_valid), 32'd1);
    chk("b2b sltu result", result, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b idle valid", 32'(out_valid), 32'd0);

    // Backpressure: result held, later input ignored until the consumer accepts.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctl = 4'b0100; op_a = 32'h1; op_b = 32'd31;
    @(posedge clk); #1;
    alu_ctl = 4'b0010; op_a = 32'd5; op_b = 32'd6;
    g_lat = 0;
    while (!out_valid && g_lat < 100) begin
      @(negedge clk);
      g_lat++;
    end
    chk("bp valid seen", 32'(out_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d result", c), result, 32'h8000_0000);
      chk($sformatf("bp hold%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp release valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);

    // Reset three cycles into a 20-bit SRL.
    in_valid = 1'b1; alu_ctl = 4'b0101; op_a = 32'hFFFF_0000; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no stale valid", 32'(seen), 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      m = model(c, a, b);
      run_op(c, a, b, g_res, g_z, g_ill, g_lat, g_busy);
      chk($sformatf("rnd%0d ctl=%h result", i, c), g_res, m[31:0]);
      chk($sformatf("rnd%0d zero", i), 32'(g_z), 32'(m[31:0] == 32'd0));
      chk($sformatf("rnd%0d illegal", i), 32'(g_ill), 32'(m[32]));
      chk($sformatf("rnd%0d latency", i), 32'(g_lat), 32'(model_lat(c, b)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. Sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALUCtl code and two operands; produces a registered result and a zero flag for branch resolution.
- Uses valid/ready handshakes on both sides.
- Shifts run iteratively, one bit per cycle, to keep area low. A parameter selects a single-cycle barrel shift instead.

Parameters:
- XLEN, 32: operand/result width (power of 2, ≥8).
- FAST_SHIFT, 0: 0 = iterative shifter (1 bit/cycle); 1 = single-cycle shift.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation this cycle.
- alu_ctl  in  4  operation code, see Behaviour.
- op_a  in  XLEN  operand A (rs1/PC).
- op_b  in  XLEN  operand B (rs2/imm). Shift amount is op_b[log2(XLEN)-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0.
- illegal  out  1  alu_ctl was not a defined code; result forced to 0.

Behaviour:
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA
  - 1000 SLT (signed), 1001 SLTU
  - All others: illegal.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. SLT/SLTU return 1 or 0, zero-extended.
- Shift amount: masked to log2(XLEN) bits. Upper op_b bits are ignored.
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions:
  - IDLE + accept (in_valid&&in_ready), non-shift or shamt==0 or FAST_SHIFT=1: compute, register result, go to DONE next cycle. Latency 1.
  - IDLE + accept, shift with shamt>0 and FAST_SHIFT=0:
    - Load op_a and shamt into working registers; go to SHIFT.
    - Each SHIFT cycle shifts by 1 (SRA replicates the MSB) and decrements the count.
    - When the count reaches 0, go to DONE.
    - out_valid rises shamt+1 cycles after the accept edge.
  - DONE + out_ready && !in_valid: go to IDLE.
  - DONE + out_ready && in_valid: back-to-back accept in the same cycle; the new op follows the IDLE rules. Throughput is 1 op/cycle for non-shifts.
  - DONE + !out_ready: hold. result, zero and illegal stay stable; inputs are ignored (in_ready=0).
- zero and illegal are registered together with result and are valid only while out_valid=1.
- Inputs are sampled only on the accept edge. Changes afterwards have no effect on an in-flight op.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, illegal=0, shift counter=0. in_ready=1 from the first cycle after reset deassert.
- Reset mid-operation (SHIFT or DONE): the op is discarded, outputs return to reset values, and no result is produced.
- in_valid while in SHIFT: not accepted (in_ready=0). The upstream stage must hold.

Decomposition:
- Shared package alu_pkg holds:
  - ALUCtl code localparams (ALU_AND … ALU_SLTU), reused by the ALU control decoder.
  - FSM state encoding (S_IDLE, S_SHIFT, S_DONE).
  - SHAMT_W = $clog2(XLEN).
- One sub-module, alu_shift_iter: the iterative shifter with load, step, done and direction/arith inputs. It is bypassed when FAST_SHIFT=1.

Test Plan:
- ADD: op_a=0x7FFFFFFF, op_b=1, alu_ctl=0010, out_ready=1 → out_valid the next cycle; result=0x80000000, zero=0, illegal=0.
- SUB for branch: op_a=op_b=0x1234, alu_ctl=0110 → result=0, zero=1. Follow back-to-back with SLT op_a=0xFFFFFFFF, op_b=1 → result=1, and SLTU with the same operands → result=0. Three ops on three consecutive accept cycles.
- SRA: op_a=0x80000000, op_b=0x24 (shamt=4), FAST_SHIFT=0 → in_ready=0 for 4 cycles; out_valid 5 cycles after accept; result=0xF8000000.
- Backpressure: SLL op_a=1, op_b=31 with out_ready=0 for 10 cycles after out_valid → result=0x80000000 held stable, in_ready=0. Release out_ready → one handshake, state returns to IDLE.
- Illegal: alu_ctl=1111 → result=0, illegal=1, latency 1. Then alu_ctl=0000 with op_a=0xF0F0, op_b=0xFF00 → result=0xF000, illegal=0.
- Reset mid-shift: SRL shamt=20, assert rst 3 cycles after accept → out_valid=0 immediately (async), result=0. After release, in_ready=1 and no stale result appears.
